// File: rtl/sigma_delta_adc.sv
// First-order sigma-delta ADC back end: comparator sync, 1-bit feedback, decimation to offset binary, valid/ack output.
// Define SDADC_SINC2_EN for a 2nd-order CIC decimator; otherwise a boxcar ones-counter is used.
module sigma_delta_adc #(
  parameter int MSBO       = 11,
  parameter int DECIM_LOG2 = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            CompIn,
  output logic            FbOut,
  output logic [MSBO:0]   DataOut,
  output logic            DataValid,
  input  logic            DataAck,
  output logic            Overrun
);

  localparam int W = MSBO + 1;
`ifdef SDADC_SINC2_EN
  localparam int K = 2 * DECIM_LOG2;
`else
  localparam int K = DECIM_LOG2;
`endif
  localparam int AW  = K + 1;
  localparam int XW  = (K >= W) ? K : W;
  localparam int SHR = (K >= W) ? K - W : 0;
  localparam int SHL = (K >= W) ? 0 : W - K;

  logic                  sync1, sync2;
  logic [DECIM_LOG2-1:0] phase;
  logic                  win_end;
  logic [AW-1:0]         raw;
  logic                  sample_ok;
  logic [XW-1:0]         ext;
  logic [MSBO:0]         scaled;

  assign win_end = (phase == '1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      FbOut <= 1'b0;
      phase <= '0;
    end else begin
      sync1 <= CompIn;
      sync2 <= sync1;
      FbOut <= sync2;
      phase <= phase + 1'b1;
    end
  end

`ifdef SDADC_SINC2_EN
  logic [AW-1:0] int1, int2, int1_nxt, int2_nxt, comb1_d, comb2_d, diff1;
  logic          primed;

  assign int1_nxt  = int1 + AW'(FbOut);
  assign int2_nxt  = int2 + int1_nxt;
  assign diff1     = int2_nxt - comb1_d;
  assign raw       = diff1 - comb2_d;
  assign sample_ok = primed;

  // The first window end after reset only loads the comb delays.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      int1    <= '0;
      int2    <= '0;
      comb1_d <= '0;
      comb2_d <= '0;
      primed  <= 1'b0;
    end else begin
      int1 <= int1_nxt;
      int2 <= int2_nxt;
      if (win_end) begin
        comb1_d <= int2_nxt;
        comb2_d <= diff1;
        primed  <= 1'b1;
      end
    end
  end
`else
  logic [AW-1:0] acc;

  assign raw       = acc + AW'(FbOut);
  assign sample_ok = 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc <= '0;
    end else if (win_end) begin
      acc <= '0;
    end else begin
      acc <= raw;
    end
  end
`endif

  // raw[K] is only set by a full-scale window, which maps to all ones.
  assign ext = XW'(raw[K-1:0]);

  always_comb begin
    scaled = W'((ext >> SHR) << SHL);
    if (raw[K]) scaled = '1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DataOut   <= W'(1) << MSBO;
      DataValid <= 1'b0;
      Overrun   <= 1'b0;
    end else if (win_end && sample_ok) begin
      DataOut   <= scaled;
      DataValid <= 1'b1;
      if (DataValid && !DataAck) Overrun <= 1'b1;
    end else if (DataAck && DataValid) begin
      DataValid <= 1'b0;
      Overrun   <= 1'b0;
    end
  end

endmodule
